// File: rtl/calc_sequencer.sv
// calc_sequencer: operand-entry and execute controller for the 8-bit calculator.
// Two operands and an opcode are captured under pushbutton control. The result and its
// signed-overflow flag are then registered, and a one-cycle load strobe is sent downstream.
module calc_sequencer (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Enter,
    input  logic [7:0] Sw,
    input  logic [1:0] Op,
    output logic [7:0] Result,
    output logic       LoadOU,
    output logic       Ovf,
    output logic [1:0] Phase
);

    typedef enum logic [1:0] {
        StGetA = 2'b00,
        StGetB = 2'b01,
        StExec = 2'b10,
        StShow = 2'b11
    } state_e;

    state_e     state_q;
    logic       s1_q, s2_q, dly_q;
    logic [7:0] a_q, b_q;
    logic [1:0] opr_q;
    logic [7:0] result_q;
    logic       ovf_q;
    logic       load_q;

    logic       press;
    logic [7:0] alu_r;
    logic       alu_ovf;

    // Rising-edge detect on the synchronised pushbutton.
    assign press = s2_q & ~dly_q;

    // ALU on the captured operands; only consumed in EXEC.
    always_comb begin
        alu_r   = 8'h00;
        alu_ovf = 1'b0;
        unique case (opr_q)
            2'b00: begin
                alu_r   = a_q + b_q;
                alu_ovf = (a_q[7] == b_q[7]) & (alu_r[7] != a_q[7]);
            end
            2'b01: begin
                alu_r   = a_q - b_q;
                alu_ovf = (a_q[7] != b_q[7]) & (alu_r[7] != a_q[7]);
            end
            2'b10: alu_r = a_q & b_q;
            2'b11: alu_r = a_q | b_q;
            default: begin
                alu_r   = 8'h00;
                alu_ovf = 1'b0;
            end
        endcase
    end

    // Synchroniser, operand capture and sequencing FSM with registered outputs.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= StGetA;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            dly_q    <= 1'b0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            opr_q    <= 2'b00;
            result_q <= 8'h00;
            ovf_q    <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            s1_q   <= Enter;
            s2_q   <= s1_q;
            dly_q  <= s2_q;
            load_q <= 1'b0;
            case (state_q)
                StGetA: begin
                    if (press) begin
                        a_q     <= Sw;
                        state_q <= StGetB;
                    end
                end
                StGetB: begin
                    if (press) begin
                        b_q     <= Sw;
                        opr_q   <= Op;
                        state_q <= StExec;
                    end
                end
                // Unconditional single cycle; a press arriving here is dropped.
                StExec: begin
                    result_q <= alu_r;
                    ovf_q    <= alu_ovf;
                    load_q   <= 1'b1;
                    state_q  <= StShow;
                end
                StShow: begin
                    if (press) begin
                        state_q <= StGetA;
                    end
                end
                default: state_q <= StGetA;
            endcase
        end
    end

    assign Result = result_q;
    assign Ovf    = ovf_q;
    assign LoadOU = load_q;
    assign Phase  = state_q;

endmodule
